pipeline_control: RTL and testbench
===================================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have parameter LOAD_BUBBLES, default 1, meaning the number of bubble cycles inserted per load-use hazard; the legal range is 1..3.
REQ-002 SHALL have parameter PERF_W, default 32, meaning the width of the stall-cycle counter.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 if_id_rs1, if_id_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 id_ex_rd  input  5  destination register of the instruction in EX.
REQ-007 id_ex_memread  input  1  the instruction in EX is a load.
REQ-008 ex_branch_taken  input  1  the branch or jump in EX redirects the PC this cycle.
REQ-009 dmem_req, dmem_ready  input  1 each  MEM-stage access pending, and the access completes this cycle.
REQ-010 pc_we, if_id_we, id_ex_we, ex_mem_we  output  1 each  stage-register write enables.
REQ-011 if_id_flush, id_ex_flush  output  1 each  load a bubble (NOP) into the stage register.
REQ-012 stall_cycles  output  PERF_W  saturating count of cycles with pc_we=0.

Function
REQ-013 Control outputs SHALL be combinational from the registered state and the current inputs, so a hazard takes effect in the cycle it is detected.
REQ-014 load_use SHALL be id_ex_memread AND id_ex_rd!=0 AND (id_ex_rd==if_id_rs1 OR id_ex_rd==if_id_rs2); rd=x0 never causes a hazard.
REQ-015 mem_wait SHALL be dmem_req AND NOT dmem_ready.
REQ-016 FSM states: RUN, LOAD_STALL, MEM_WAIT.
REQ-017 Priority in every state SHALL be mem_wait > ex_branch_taken > load_use.
REQ-018 Default outputs (RUN, no event): all write enables 1, flushes 0.
REQ-019 mem_wait in any state: all four write enables 0 and both flushes 0; save the current state in ret_state; go to MEM_WAIT; bubble_cnt holds.
REQ-020 MEM_WAIT: keep outputs frozen while mem_wait=1; on dmem_ready=1 apply the ret_state outputs that same cycle and next state = ret_state.
REQ-021 ex_branch_taken in RUN or LOAD_STALL (no mem_wait): pc_we=1, if_id_flush=1, id_ex_flush=1; clear bubble_cnt; next state RUN.
REQ-022 load_use in RUN (no higher-priority event): pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1.
REQ-023 After a REQ-022 cycle, next state SHALL be RUN if LOAD_BUBBLES=1; otherwise LOAD_STALL with bubble_cnt=1.
REQ-024 LOAD_STALL: same outputs as REQ-022; bubble_cnt increments each cycle; when bubble_cnt==LOAD_BUBBLES-1, next state RUN and bubble_cnt=0.
REQ-025 load_use SHALL be ignored while in LOAD_STALL or MEM_WAIT and re-evaluated on return to RUN.
REQ-026 stall_cycles SHALL increment when pc_we=0 and SHALL saturate at all-ones without wrapping.
REQ-027 Outputs SHALL carry no X when the inputs are known.

Reset
REQ-028 With reset=1 at a rising edge: state=RUN, ret_state=RUN, bubble_cnt=0, stall_cycles=0.
REQ-029 Reset SHALL take priority over every event, including mid-LOAD_STALL and mid-MEM_WAIT.
REQ-030 The cycle after reset, outputs SHALL be the REQ-018 defaults unless an input event applies.

Structure
REQ-031 Package pipeline_control_pkg SHALL hold the state enum, REG_ADDR_W=5 and the legal LOAD_BUBBLES bounds.
REQ-032 The saturating counter SHALL be one sub-module, sat_counter (parameter width, inc input, count output); all other logic stays inline.
REQ-033 A parameter check SHALL reject LOAD_BUBBLES outside 1..3 at elaboration.

Verification
REQ-034 LOAD_BUBBLES=1: load with rd=5, ID rs1=5 -> one cycle of pc_we=0, if_id_we=0, id_ex_flush=1, then defaults; stall_cycles=1.
REQ-035 Load with rd=0, ID rs1=0 -> no stall; outputs stay at defaults.
REQ-036 LOAD_BUBBLES=3: hazard on rd=7 -> three consecutive stall cycles; stall_cycles=3.
REQ-037 LOAD_BUBBLES=2: hazard, then mem_wait for 4 cycles during LOAD_STALL -> 4 frozen cycles, then the remaining bubble, then RUN; stall_cycles=6.
REQ-038 ex_branch_taken=1 with load_use=1 in the same cycle -> flushes win, pc_we=1, no stall; ex_branch_taken with mem_wait=1 -> full freeze, flush applied only after dmem_ready.
REQ-039 PERF_W=4: 20 stalled cycles -> stall_cycles=15 and held; reset asserted in MEM_WAIT -> next cycle in RUN with count 0.

Source files
------------

// File: rtl/pipeline_control_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_control_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int LOAD_BUBBLES_MIN = 1;
    localparam int LOAD_BUBBLES_MAX = 3;
    localparam int BUBBLE_CNT_W     = 2;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic if_id_flush;
        logic id_ex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = 6'b111100;
    localparam ctrl_t CTRL_STALL   = 6'b001101;
    localparam ctrl_t CTRL_FREEZE  = 6'b000000;
    localparam ctrl_t CTRL_BRANCH  = 6'b111111;

endpackage

// File: rtl/pipeline_control_if.sv
// Hazard inputs from the datapath and stage-register controls back to it.
interface pipeline_control_if;
    import pipeline_control_pkg::*;

    logic [REG_ADDR_W-1:0] if_id_rs1;
    logic [REG_ADDR_W-1:0] if_id_rs2;
    logic [REG_ADDR_W-1:0] id_ex_rd;
    logic                  id_ex_memread;
    logic                  ex_branch_taken;
    logic                  dmem_req;
    logic                  dmem_ready;
    logic                  pc_we;
    logic                  if_id_we;
    logic                  id_ex_we;
    logic                  ex_mem_we;
    logic                  if_id_flush;
    logic                  id_ex_flush;

    modport master (
        output if_id_rs1, if_id_rs2, id_ex_rd, id_ex_memread,
               ex_branch_taken, dmem_req, dmem_ready,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush
    );

    modport slave (
        input  if_id_rs1, if_id_rs2, id_ex_rd, id_ex_memread,
               ex_branch_taken, dmem_req, dmem_ready,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush
    );

endinterface

// File: rtl/pipeline_control_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_control.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and memory-wait freezes,
// with a saturating count of cycles in which the PC was held.
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int PERF_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    pipeline_control_if.slave ctl,
    output logic [PERF_W-1:0] stall_cycles
);

    generate
        if (LOAD_BUBBLES < LOAD_BUBBLES_MIN || LOAD_BUBBLES > LOAD_BUBBLES_MAX) begin : g_bad_param
            $error("pipeline_control: LOAD_BUBBLES must be within 1..3");
        end
    endgenerate

    localparam logic [BUBBLE_CNT_W-1:0] LAST_BUBBLE = BUBBLE_CNT_W'(LOAD_BUBBLES - 1);

    state_t                  state_reg, state_next;
    state_t                  ret_state_reg, ret_state_next;
    state_t                  eff_state;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt_reg, bubble_cnt_next;
    logic                    load_use;
    logic                    mem_wait;
    logic                    stall_inc;
    ctrl_t                   ctrl;

    assign load_use = ctl.id_ex_memread && (ctl.id_ex_rd != '0) &&
                      ((ctl.id_ex_rd == ctl.if_id_rs1) || (ctl.id_ex_rd == ctl.if_id_rs2));
    assign mem_wait = ctl.dmem_req && !ctl.dmem_ready;

    // On the cycle memory completes, MEM_WAIT behaves exactly like the state it interrupted.
    assign eff_state = (state_reg == MEM_WAIT) ? ret_state_reg : state_reg;

    always_comb begin
        ctrl            = CTRL_DEFAULT;
        state_next      = state_reg;
        ret_state_next  = ret_state_reg;
        bubble_cnt_next = bubble_cnt_reg;

        if (mem_wait) begin
            ctrl       = CTRL_FREEZE;
            state_next = MEM_WAIT;
            if (state_reg != MEM_WAIT) begin
                ret_state_next = state_reg;
            end
        end else if (ctl.ex_branch_taken) begin
            ctrl            = CTRL_BRANCH;
            state_next      = RUN;
            bubble_cnt_next = '0;
        end else if (eff_state == LOAD_STALL) begin
            ctrl = CTRL_STALL;
            if (bubble_cnt_reg == LAST_BUBBLE) begin
                state_next      = RUN;
                bubble_cnt_next = '0;
            end else begin
                state_next      = LOAD_STALL;
                bubble_cnt_next = bubble_cnt_reg + BUBBLE_CNT_W'(1);
            end
        end else if (load_use) begin
            ctrl = CTRL_STALL;
            if (LOAD_BUBBLES == 1) begin
                state_next = RUN;
            end else begin
                state_next      = LOAD_STALL;
                bubble_cnt_next = BUBBLE_CNT_W'(1);
            end
        end else begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= RUN;
            ret_state_reg  <= RUN;
            bubble_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            ret_state_reg  <= ret_state_next;
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

    assign ctl.pc_we       = ctrl.pc_we;
    assign ctl.if_id_we    = ctrl.if_id_we;
    assign ctl.id_ex_we    = ctrl.id_ex_we;
    assign ctl.ex_mem_we   = ctrl.ex_mem_we;
    assign ctl.if_id_flush = ctrl.if_id_flush;
    assign ctl.id_ex_flush = ctrl.id_ex_flush;

    assign stall_inc = !ctrl.pc_we;

    sat_counter #(
        .WIDTH(PERF_W)
    ) u_stall_cnt (
        .clock(clock),
        .reset(reset),
        .inc  (stall_inc),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench: four controller instances with different parameters, table-driven vectors
// through a scoreboard queue, plus hand sequences for saturation and reset mid-stall.
module tb_pipeline_control;
    import pipeline_control_pkg::*;

    localparam logic [5:0] DEF = 6'b111100;
    localparam logic [5:0] STL = 6'b001101;
    localparam logic [5:0] FRZ = 6'b000000;
    localparam logic [5:0] BRF = 6'b111111;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_control_if if1 ();
    pipeline_control_if if2 ();
    pipeline_control_if if3 ();
    pipeline_control_if if4 ();

    logic [31:0] sc1, sc2, sc3;
    logic [3:0]  sc4;

    pipeline_control #(.LOAD_BUBBLES(1), .PERF_W(32)) dut1 (.clock(clk), .reset(reset), .ctl(if1), .stall_cycles(sc1));
    pipeline_control #(.LOAD_BUBBLES(2), .PERF_W(32)) dut2 (.clock(clk), .reset(reset), .ctl(if2), .stall_cycles(sc2));
    pipeline_control #(.LOAD_BUBBLES(3), .PERF_W(32)) dut3 (.clock(clk), .reset(reset), .ctl(if3), .stall_cycles(sc3));
    pipeline_control #(.LOAD_BUBBLES(1), .PERF_W(4))  dut4 (.clock(clk), .reset(reset), .ctl(if4), .stall_cycles(sc4));

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       memread;
        logic       br;
        logic       dreq;
        logic       drdy;
    } in_t;

    typedef struct {
        int         sel;
        in_t        in;
        logic [5:0] exp;
        bit         chk_cnt;
        int         exp_cnt;
    } vec_t;

    typedef struct {
        int         sel;
        int         idx;
        logic [5:0] exp;
        bit         chk_cnt;
        int         exp_cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic in_t mk(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                               logic mr, logic br, logic dq, logic dr);
        in_t v;
        v = '{rs1: rs1, rs2: rs2, rd: rd, memread: mr, br: br, dreq: dq, drdy: dr};
        return v;
    endfunction

    task automatic add(int sel, in_t v, logic [5:0] exp, bit chk_cnt = 1'b0, int exp_cnt = 0);
        vec_t r;
        r = '{sel: sel, in: v, exp: exp, chk_cnt: chk_cnt, exp_cnt: exp_cnt};
        vecs.push_back(r);
    endtask

    // Selected instance gets the vector; every other instance sits idle.
    task automatic apply_in(int sel, in_t v);
        {if1.if_id_rs1, if1.if_id_rs2, if1.id_ex_rd, if1.id_ex_memread, if1.ex_branch_taken, if1.dmem_req, if1.dmem_ready} = (sel == 1) ? v : '0;
        {if2.if_id_rs1, if2.if_id_rs2, if2.id_ex_rd, if2.id_ex_memread, if2.ex_branch_taken, if2.dmem_req, if2.dmem_ready} = (sel == 2) ? v : '0;
        {if3.if_id_rs1, if3.if_id_rs2, if3.id_ex_rd, if3.id_ex_memread, if3.ex_branch_taken, if3.dmem_req, if3.dmem_ready} = (sel == 3) ? v : '0;
        {if4.if_id_rs1, if4.if_id_rs2, if4.id_ex_rd, if4.id_ex_memread, if4.ex_branch_taken, if4.dmem_req, if4.dmem_ready} = (sel == 4) ? v : '0;
    endtask

    function automatic logic [5:0] outs(int sel);
        case (sel)
            1: return {if1.pc_we, if1.if_id_we, if1.id_ex_we, if1.ex_mem_we, if1.if_id_flush, if1.id_ex_flush};
            2: return {if2.pc_we, if2.if_id_we, if2.id_ex_we, if2.ex_mem_we, if2.if_id_flush, if2.id_ex_flush};
            3: return {if3.pc_we, if3.if_id_we, if3.id_ex_we, if3.ex_mem_we, if3.if_id_flush, if3.id_ex_flush};
            default: return {if4.pc_we, if4.if_id_we, if4.id_ex_we, if4.ex_mem_we, if4.if_id_flush, if4.id_ex_flush};
        endcase
    endfunction

    function automatic logic [31:0] cnt(int sel);
        case (sel)
            1: return sc1;
            2: return sc2;
            3: return sc3;
            default: return {28'd0, sc4};
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        exp_t e;

        // DUT1, LOAD_BUBBLES=1
        add(1, mk(0, 0, 0, 0, 0, 0, 0), DEF);
        add(1, mk(5, 0, 5, 1, 0, 0, 0), STL);
        add(1, mk(0, 0, 0, 0, 0, 0, 0), DEF);
        add(1, mk(0, 0, 0, 1, 0, 0, 0), DEF);
        add(1, mk(0, 3, 3, 1, 1, 0, 0), BRF);
        add(1, mk(0, 0, 0, 0, 0, 0, 0), DEF, 1'b1, 1);
        // DUT3, LOAD_BUBBLES=3: hazard stays visible but is ignored while stalling
        add(3, mk(0, 7, 7, 1, 0, 0, 0), STL);
        add(3, mk(0, 7, 7, 1, 0, 0, 0), STL);
        add(3, mk(0, 7, 7, 1, 0, 0, 0), STL);
        add(3, mk(0, 0, 0, 0, 0, 0, 0), DEF, 1'b1, 3);
        // DUT2, LOAD_BUBBLES=2: memory wait interrupts the stall
        add(2, mk(9, 0, 9, 1, 0, 0, 0), STL);
        add(2, mk(0, 0, 0, 0, 0, 1, 0), FRZ);
        add(2, mk(0, 0, 0, 0, 0, 1, 0), FRZ);
        add(2, mk(0, 0, 0, 0, 0, 1, 0), FRZ);
        add(2, mk(0, 0, 0, 0, 0, 1, 0), FRZ);
        add(2, mk(0, 0, 0, 0, 0, 1, 1), STL);
        add(2, mk(0, 0, 0, 0, 0, 0, 0), DEF, 1'b1, 6);
        // branch during memory wait, then branch during a load stall
        add(2, mk(0, 0, 0, 0, 1, 1, 0), FRZ);
        add(2, mk(0, 0, 0, 0, 1, 1, 1), BRF);
        add(2, mk(0, 0, 0, 0, 0, 0, 0), DEF, 1'b1, 7);
        add(2, mk(4, 0, 4, 1, 0, 0, 0), STL);
        add(2, mk(0, 0, 0, 0, 1, 0, 0), BRF);
        add(2, mk(0, 0, 0, 0, 0, 0, 0), DEF, 1'b1, 8);

        reset = 1'b1;
        apply_in(0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #2;
        for (int s = 1; s <= 4; s++) begin
            chk($sformatf("reset_count_dut%0d", s), cnt(s), 32'd0);
            chk($sformatf("reset_outputs_dut%0d", s), 32'(outs(s)), 32'(DEF));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply_in(vecs[i].sel, vecs[i].in);
            exp_q.push_back('{sel: vecs[i].sel, idx: i, exp: vecs[i].exp,
                              chk_cnt: vecs[i].chk_cnt, exp_cnt: vecs[i].exp_cnt});
            #2;
            e = exp_q.pop_front();
            $display("vec %0d dut%0d outs=%b exp=%b count=%0d", e.idx, e.sel, outs(e.sel), e.exp, cnt(e.sel));
            chk($sformatf("vec%0d_outputs", e.idx), 32'(outs(e.sel)), 32'(e.exp));
            if (e.chk_cnt) chk($sformatf("vec%0d_stall_cycles", e.idx), cnt(e.sel), 32'(e.exp_cnt));
        end

        // DUT4, PERF_W=4: counter saturates at 15
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            apply_in(4, mk(0, 0, 0, 0, 0, 1, 0));
            #2;
            $display("sat cycle %0d outs=%b count=%0d", c, outs(4), sc4);
            chk($sformatf("sat%0d_outputs", c), 32'(outs(4)), 32'(FRZ));
            if (c == 14) chk("sat_count_14", cnt(4), 32'd14);
            if (c == 20) chk("sat_count_held", cnt(4), 32'd15);
        end

        // DUT3 enters a load stall while DUT4 is still waiting on memory; then reset both
        @(negedge clk);
        if3.id_ex_memread = 1'b1;
        if3.id_ex_rd      = 5'd7;
        if3.if_id_rs1     = 5'd7;
        #2;
        chk("pre_reset_dut3_stall", 32'(outs(3)), 32'(STL));
        chk("pre_reset_dut4_freeze", 32'(outs(4)), 32'(FRZ));
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk("in_load_stall_dut3", 32'(outs(3)), 32'(STL));
        @(negedge clk);
        reset = 1'b0;
        apply_in(0, '0);
        #2;
        $display("post reset dut3 outs=%b dut4 outs=%b count4=%0d", outs(3), outs(4), sc4);
        chk("post_reset_dut3_run", 32'(outs(3)), 32'(DEF));
        chk("post_reset_dut4_run", 32'(outs(4)), 32'(DEF));
        for (int s = 1; s <= 4; s++) begin
            chk($sformatf("post_reset_count_dut%0d", s), cnt(s), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
